// File: rtl/spi_slave.sv
// SPI mode-3 slave moving 128-bit frames, with the SPI inputs synchronized into clk.
// Define SPI_LSB_FIRST_EN to transmit and receive LSB first; the default order is MSB first.
`timescale 1ns/1ps

module spi_slave (
  input  logic         clk,
  input  logic         rst,
  input  logic         Cs,
  input  logic         DClk,
  input  logic         Rx,
  output logic         Tx,
  input  logic [127:0] Tx_packet,
  output logic         TxGetNext,
  output logic         PktComplete,
  output logic [127:0] rxedFrame
);

  // state     | meaning
  // ST_IDLE   | Cs high or not yet seen falling; waiting for a transaction
  // ST_ACTIVE | Cs low; frames are shifted on synchronized DClk edges
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_cs_s1, r_cs_s2, r_cs_d;
  logic         r_dclk_s1, r_dclk_s2, r_dclk_d;
  logic         r_rx_s1, r_rx_s2;

  logic [127:0] r_tx_shift;
  logic [127:0] r_rx_shift;
  logic [127:0] r_rxed_frame;
  logic [6:0]   r_bit_cnt;
  logic         r_reload;
  logic         r_get_next;
  logic         r_pkt_done;

  logic         w_cs_fall;
  logic         w_dclk_rise;
  logic         w_dclk_fall;
  logic         w_load;
  logic         w_abort;
  logic         w_rise;
  logic         w_fall;
  logic [127:0] w_rx_next;
  logic [127:0] w_tx_shifted;
  logic         w_tx_bit;

  // Cs and DClk reset high so that reset release looks like an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_dclk_s1 <= 1'b1;
      r_dclk_s2 <= 1'b1;
      r_dclk_d  <= 1'b1;
      r_rx_s1   <= 1'b0;
      r_rx_s2   <= 1'b0;
    end else begin
      r_cs_s1   <= Cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_dclk_s1 <= DClk;
      r_dclk_s2 <= r_dclk_s1;
      r_dclk_d  <= r_dclk_s2;
      r_rx_s1   <= Rx;
      r_rx_s2   <= r_rx_s1;
    end
  end

  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_dclk_rise = r_dclk_s2 & ~r_dclk_d;
  assign w_dclk_fall = ~r_dclk_s2 & r_dclk_d;

`ifdef SPI_LSB_FIRST_EN
  assign w_rx_next    = {r_rx_s2, r_rx_shift[127:1]};
  assign w_tx_shifted = {1'b0, r_tx_shift[127:1]};
  assign w_tx_bit     = r_tx_shift[0];
`else
  assign w_rx_next    = {r_rx_shift[126:0], r_rx_s2};
  assign w_tx_shifted = {r_tx_shift[126:0], 1'b0};
  assign w_tx_bit     = r_tx_shift[127];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DClk edges are only forwarded while Cs is low, so a Cs rise beats any coincident edge.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_abort     = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_load      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (r_cs_s2) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_rise = w_dclk_rise;
          w_fall = w_dclk_fall;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_rxed_frame <= '0;
      r_bit_cnt    <= '0;
      r_reload     <= 1'b0;
      r_get_next   <= 1'b0;
      r_pkt_done   <= 1'b0;
    end else begin
      r_get_next <= 1'b0;
      r_pkt_done <= 1'b0;
      if (w_abort) begin
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
        r_reload   <= 1'b0;
      end else if (w_load) begin
        r_tx_shift <= Tx_packet;
        r_rx_shift <= '0;
        r_bit_cnt  <= '0;
        r_reload   <= 1'b0;
        r_get_next <= 1'b1;
      end else begin
        if (w_rise) begin
          r_rx_shift <= w_rx_next;
          if (r_bit_cnt == 7'd127) begin
            r_rxed_frame <= w_rx_next;
            r_pkt_done   <= 1'b1;
            r_bit_cnt    <= '0;
            r_reload     <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 7'd1;
          end
        end
        // The first fall of a transaction only exposes the bit already loaded.
        if (w_fall) begin
          if (r_reload) begin
            r_tx_shift <= Tx_packet;
            r_get_next <= 1'b1;
            r_reload   <= 1'b0;
          end else if (r_bit_cnt != 7'd0) begin
            r_tx_shift <= w_tx_shifted;
          end
        end
      end
    end
  end

  assign Tx          = ~r_cs_s2 & w_tx_bit;
  assign TxGetNext   = r_get_next;
  assign PktComplete = r_pkt_done;
  assign rxedFrame   = r_rxed_frame;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave acting as a mode-3 master; it follows SPI_LSB_FIRST_EN for bit order.
`timescale 1ns/1ps

module tb_spi_slave;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         Cs = 1'b1;
  logic         DClk = 1'b1;
  logic         Rx = 1'b0;
  logic [127:0] Tx_packet = '0;
  logic         Tx;
  logic         TxGetNext;
  logic         PktComplete;
  logic [127:0] rxedFrame;

  int n_cmp = 0;
  int n_err = 0;
  int gn_cnt = 0;
  int pc_cnt = 0;
  logic [127:0] tx_got;

  localparam logic [127:0] P1 = 128'h0FF101010FF101010101010101010101;
  localparam logic [127:0] P2 = 128'hA5A5_0F0F_3C3C_FFFF_0000_1234_8001_7E7E;
  localparam logic [127:0] P3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P4 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  localparam logic [127:0] R1 = 128'hDEADBEEF_00000000_CAFEBABE_12345678;
  localparam logic [127:0] R2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] R3 = 128'h5555AAAA_C0FFEE00_13579BDF_2468ACE0;

  spi_slave dut (
    .clk         (clk),
    .rst         (rst),
    .Cs          (Cs),
    .DClk        (DClk),
    .Rx          (Rx),
    .Tx          (Tx),
    .Tx_packet   (Tx_packet),
    .TxGetNext   (TxGetNext),
    .PktComplete (PktComplete),
    .rxedFrame   (rxedFrame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (TxGetNext)   gn_cnt++;
    if (PktComplete) pc_cnt++;
  end

  function automatic int bit_at(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return 127 - k;
`endif
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic mosi, output logic miso);
    DClk = 1'b0;
    Rx   = mosi;
    #50;
    miso = Tx;
    DClk = 1'b1;
    #50;
  endtask

  task automatic xfer(input logic [127:0] rxv, input int k0, input int k1);
    logic m;
    for (int k = k0; k < k1; k++) begin
      spi_bit(rxv[bit_at(k)], m);
      tx_got[bit_at(k)] = m;
    end
  endtask

  initial begin
    int g0;
    int p0;
    logic m;
    logic [127:0] mask;

    #20;
    check("rst_Tx", {127'b0, Tx}, '0);
    check("rst_TxGetNext", {127'b0, TxGetNext}, '0);
    check("rst_PktComplete", {127'b0, PktComplete}, '0);
    check("rst_rxedFrame", rxedFrame, '0);
    rst = 1'b1;
    #100;

    // DClk toggling with Cs high
    g0 = gn_cnt; p0 = pc_cnt;
    Tx_packet = P1;
    for (int i = 0; i < 6; i++) begin
      spi_bit(1'b1, m);
      check("cs_high_Tx", {127'b0, m}, '0);
    end
    check("cs_high_gn", 128'(gn_cnt - g0), 128'd0);
    check("cs_high_pc", 128'(pc_cnt - p0), 128'd0);

    // Single frame: transmit P1, receive R1
    g0 = gn_cnt; p0 = pc_cnt;
    tx_got = '0;
    Cs = 1'b0;
    #100;
    check("load_gn", 128'(gn_cnt - g0), 128'd1);
    xfer(R1, 0, 128);
    check("f1_tx", tx_got, P1);
    check("f1_rxed", rxedFrame, R1);
    check("f1_pc", 128'(pc_cnt - p0), 128'd1);
    check("f1_gn", 128'(gn_cnt - g0), 128'd1);
    Tx_packet = P2;
    DClk = 1'b0;
    #50;
    check("reload_gn", 128'(gn_cnt - g0), 128'd2);
    check("reload_Tx", {127'b0, Tx}, {127'b0, P2[bit_at(0)]});
    Cs = 1'b1;
    #50;
    DClk = 1'b1;
    #100;
    check("idle_Tx", {127'b0, Tx}, '0);
    check("idle_pc", 128'(pc_cnt - p0), 128'd1);

    // 140 bits with Cs low, abort 12 bits into the second frame
    g0 = gn_cnt; p0 = pc_cnt;
    Tx_packet = P3;
    tx_got = '0;
    Cs = 1'b0;
    #100;
    xfer(R2, 0, 128);
    check("bb_tx1", tx_got, P3);
    check("bb_rxed1", rxedFrame, R2);
    Tx_packet = P4;
    tx_got = '0;
    xfer(R3, 0, 1);
    Tx_packet = P1;
    xfer(R3, 1, 12);
    mask = '0;
    for (int k = 0; k < 12; k++) mask[bit_at(k)] = 1'b1;
    check("bb_tx2_head", tx_got & mask, P4 & mask);
    check("bb_gn", 128'(gn_cnt - g0), 128'd2);
    Cs = 1'b1;
    #150;
    check("abort_rxed", rxedFrame, R2);
    check("abort_pc", 128'(pc_cnt - p0), 128'd1);
    check("abort_Tx", {127'b0, Tx}, '0);

    // Reset mid-frame, then a fresh full frame
    Tx_packet = P3;
    Cs = 1'b0;
    #100;
    xfer(R1, 0, 64);
    rst = 1'b0;
    #20;
    check("midrst_rxed", rxedFrame, '0);
    check("midrst_Tx", {127'b0, Tx}, '0);
    check("midrst_gn", {127'b0, TxGetNext}, '0);
    Cs = 1'b1;
    #40;
    rst = 1'b1;
    #100;
    g0 = gn_cnt; p0 = pc_cnt;
    check("postrst_rxed", rxedFrame, '0);
    Tx_packet = P2;
    tx_got = '0;
    Cs = 1'b0;
    #100;
    xfer(R3, 0, 128);
    check("postrst_tx", tx_got, P2);
    check("postrst_rxed_new", rxedFrame, R3);
    check("postrst_pc", 128'(pc_cnt - p0), 128'd1);
    check("postrst_gn", 128'(gn_cnt - g0), 128'd1);
    Cs = 1'b1;
    #100;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state is in this domain; frequency SHALL be at least 4x the DClk frequency.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 Cs  input  1  chip select, active low; asynchronous to clk.
REQ-005 DClk  input  1  SPI clock, idle high (CPOL=1); asynchronous to clk.
REQ-006 Rx  input  1  serial data from the master (MOSI).
REQ-007 Tx  output  1  serial data to the master (MISO).
REQ-008 Tx_packet  input  128  next frame to transmit; sampled at load events only.
REQ-009 TxGetNext  output  1  one-clk pulse; Tx_packet has just been consumed and the next frame may be presented.
REQ-010 PktComplete  output  1  one-clk pulse; a full 128-bit frame has been received.
REQ-011 rxedFrame  output  128  last completely received frame; holds until the next completion.

Function
REQ-012 Cs, DClk and Rx SHALL pass through 2-flop synchronizers; DClk rise and fall SHALL be detected on the synchronized signal.
REQ-013 Mode 3 SHALL apply: Rx is sampled on DClk rising edges; Tx changes on DClk falling edges.
REQ-014 Frames SHALL be 128 bits, MSB first (bit 127 first), unless SPI_LSB_FIRST_EN is defined.
REQ-015 On synchronized Cs falling: load Tx_packet into the tx shift register, clear the bit counter (0..127), and pulse TxGetNext for one clk.
REQ-016 While Cs is low: Tx = tx_shift[127].
REQ-017 While Cs is high: Tx = 0.
REQ-018 Each DClk rise with Cs low SHALL shift the synchronized Rx into rx_shift[0] and increment the bit counter.
REQ-019 On the DClk rise where the bit counter is 127:
- rxedFrame <= {rx_shift[126:0], Rx};
- PktComplete pulses one clk;
- the counter wraps to 0;
- reload_pending is set.
REQ-020 DClk fall with Cs low, reload_pending set: load Tx_packet, pulse TxGetNext, clear reload_pending.
REQ-021 DClk fall with Cs low, counter > 0: shift tx_shift left by 1.
REQ-022 DClk fall with Cs low, counter = 0 and no reload pending (first fall of a transaction): no shift.
REQ-023 Back-to-back frames with Cs held low SHALL be seamless, with no gap bits.
REQ-024 Cs rising mid-frame SHALL abort the frame: discard partial rx bits, clear counter and reload_pending, leave rxedFrame unchanged, no PktComplete.
REQ-025 DClk edges while Cs is high SHALL be ignored.
REQ-026 If Cs rises and a DClk edge occurs in the same clk, Cs SHALL win.

Reset
REQ-027 While rst = 0, all outputs SHALL be 0: Tx, TxGetNext, PktComplete, rxedFrame.
REQ-028 While rst = 0, all internal state SHALL be 0: shift registers, counter, reload_pending, synchronizers (DClk and Cs sync regs reset to 1).
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, the block waits for a fresh Cs falling edge.

Configuration
REQ-030 With SPI_LSB_FIRST_EN defined, transmit and receive SHALL be LSB first: Tx = tx_shift[0], the tx register shifts right, and received bits enter at bit 127 and shift right. Without the macro, MSB-first behaviour per REQ-014 applies.

Verification
REQ-031 Tx_packet=128'h0FF101010FF101010101010101010101, Cs low, 128 DClk cycles -> Tx bits on the rising edges equal Tx_packet MSB first; TxGetNext pulses once at Cs fall and once after the 128th rise.
REQ-032 Master drives Rx = 128'hDEADBEEF_00000000_CAFEBABE_12345678 MSB first -> PktComplete pulses once; rxedFrame equals that value.
REQ-033 Cs low for 140 DClk cycles:
- PktComplete pulses once;
- second frame starts with bit 127 of the Tx_packet value present at the second TxGetNext;
- Cs rise after 12 bits of the second frame -> rxedFrame unchanged, no second PktComplete.
REQ-034 rst asserted after 64 bits, then released, then a full 128-bit frame -> rxedFrame = 0 during reset; afterwards it holds only the new frame.
REQ-035 DClk toggling with Cs high -> no TxGetNext, no PktComplete, Tx = 0.
REQ-036 With SPI_LSB_FIRST_EN defined, repeat the REQ-031 and REQ-032 stimulus -> bit order reversed; rxedFrame matches.
